cdu_counter_scheduler: RTL and testbench
========================================

// Module: cdu_counter_scheduler
// PURPOSE
//  Shares the single read-counter update path among NCHAN CDU angle channels. It gets the phase
//  strobes produced by the digital-mode phase generator (FAZ1..FAZ4). In each 4-phase frame it
//  grants at most one channel and issues one +1/-1 count command for that channel.
//  Per-channel up/down requests are accumulated between grants. Interrogate (ISSI) freezes new grants.
// PARAMETERS
//  NCHAN   5  number of angle channels sharing the counter path (2..8)
//  PEND_W  4  width of per-channel signed pending accumulator; saturates at +/-(2^(PEND_W-1)-1)
// PORTS
//  clk         in   1      design clock; all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  faz1..faz4  in   1 ea   one-cycle phase strobes from the phase generator, nominal order 1,2,3,4
//  issi        in   1      interrogate in progress; level; blocks new grants
//  inc_req     in   NCHAN  per-channel one-cycle +1 request
//  dec_req     in   NCHAN  per-channel one-cycle -1 request
//  ovf_clr     in   NCHAN  clears matching sticky ovf bits
//  cmd_plus    out  1      one-cycle +1 command to the counter path
//  cmd_minus   out  1      one-cycle -1 command to the counter path
//  cmd_chan    out  3      channel index for cmd_*; 0 when no command
//  busy        out  1      a grant is in flight (SEL or HOLD)
//  ovf         out  NCHAN  sticky: accumulator saturated and a request was dropped
//  seq_err     out  1      sticky: phase strobe arrived out of order; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, accumulators 0, rr pointer = NCHAN-1 (first grant favours ch0), state IDLE.
//  Accumulate: pend[i] += inc_req[i] - dec_req[i] each cycle. inc and dec together = no change.
//    A request that would exceed saturation is dropped and sets ovf[i].
//    ovf_clr[i] clears ovf[i]; if it coincides with a new overflow, the set wins.
//  FSM states: IDLE, SEL, HOLD.
//   IDLE->SEL on faz1 & !issi & any pend!=0.
//     Winner = first nonzero channel scanning rr+1, rr+2 ... with wrap; dir latched = sign(pend).
//   SEL->HOLD on faz2. In that same cycle drive cmd_plus (dir +) or cmd_minus (dir -) for exactly
//     1 cycle, with cmd_chan = winner.
//   HOLD->IDLE on faz4. In that cycle pend[winner] moves 1 toward 0 (net with that cycle's requests,
//     then saturate); rr = winner.
//  Latency: request to command is >= 1 full frame. A request in the cycle of faz1 is visible to that
//    frame's arbitration only if it is registered before the faz1 edge. Requests in that same faz1
//    cycle wait for the next frame.
//  Direction is fixed at SEL. If opposing requests drive pend[winner] through 0 before faz4, the
//    issued command still retires; the accumulator absorbs the difference and may change sign.
//  issi asserted during SEL/HOLD: the in-flight grant completes; only the next faz1 is blocked.
//  Strobe sequence check: in SEL, faz3/faz4 before faz2 sets seq_err and returns to IDLE; no command
//    issues and pend is unchanged. In HOLD, faz1 before faz4 sets seq_err and returns to IDLE with pend
//    decremented, because the command was already issued. Multiple strobes in one cycle set seq_err;
//    the FSM holds its state.
//  Async rst mid-frame: all cleared immediately; no partial command completes.
// STRUCTURE
//  Shared package cdu_sched_pkg: state enum {IDLE,SEL,HOLD}, DIR_PLUS/DIR_MINUS constants, and a
//  clog2-based channel index width function.
//  One sub-module per channel: cdu_pend_acc (signed saturating accumulator, ovf flag, retire input).
//  Round-robin selection and FSM stay in the top level.
// TESTING
//  1 Single ch2 inc_req pulse, frames running -> one cmd_plus, cmd_chan=2, at next faz2; pend[2]=0 after faz4.
//  2 ch0,ch1,ch4 each pend=+1 together -> commands on ch0, ch1, ch4 in consecutive frames
//    (round-robin order); busy low afterward.
//  3 Eight inc_req on ch3 with PEND_W=4 -> pend saturates at 7, ovf[3]=1.
//    Next ovf_clr[3] -> 0. Seven cmd_plus are then issued.
//  4 issi high across faz1 with pend[1]=-2 -> no grant that frame.
//    issi drop -> two cmd_minus on ch1 in the next two frames.
//  5 Grant in SEL, then faz4 strobe without faz2 -> seq_err=1, no cmd_*, pend unchanged.
//    Assert rst mid-HOLD -> all outputs 0 at once.
//  6 pend[0]=+1 granted, then two dec_req before faz4 -> cmd_plus issues once; pend[0]=-2 after faz4.

Source files
------------

// File: rtl/cdu_sched_pkg.sv
// rtl/cdu_sched_pkg.sv - shared types and helpers for the CDU counter scheduler
package cdu_sched_pkg;

   typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;

   localparam logic DIR_PLUS  = 1'b0;
   localparam logic DIR_MINUS = 1'b1;

   function automatic int chan_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdu_pend_acc.sv
// rtl/cdu_pend_acc.sv - per-channel signed saturating pending-count accumulator
module cdu_pend_acc
   import cdu_sched_pkg::*;
#(
   parameter int PEND_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   input  logic                     dec,
   input  logic                     retire,
   input  logic                     retire_dir,
   input  logic                     ovf_clr,
   output logic signed [PEND_W-1:0] pend,
   output logic                     ovf
);

   localparam logic signed [PEND_W+1:0] SAT = (PEND_W+2)'(2**(PEND_W-1) - 1);

   logic signed [PEND_W+1:0] req_d, ret_d, total;
   logic                     hi, lo, ovf_set;

   always_comb begin
      req_d = '0;
      if (inc && !dec)
         req_d = (PEND_W+2)'(1);
      else if (dec && !inc)
         req_d = -(PEND_W+2)'(1);
      // A retired +1 command consumes one unit of positive backlog, and vice versa
      ret_d = '0;
      if (retire)
         ret_d = (retire_dir == DIR_PLUS) ? -(PEND_W+2)'(1) : (PEND_W+2)'(1);
      total   = (PEND_W+2)'(pend) + req_d + ret_d;
      hi      = total > SAT;
      lo      = total < -SAT;
      ovf_set = (hi || lo) && (inc ^ dec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         ovf  <= 1'b0;
      end else begin
         if (hi)
            pend <= PEND_W'(SAT);
         else if (lo)
            pend <= PEND_W'(-SAT);
         else
            pend <= PEND_W'(total);
         if (ovf_set)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/cdu_counter_scheduler.sv
// rtl/cdu_counter_scheduler.sv - round-robin arbiter sharing one +1/-1 counter path among CDU channels
module cdu_counter_scheduler
   import cdu_sched_pkg::*;
#(
   parameter int NCHAN  = 5,
   parameter int PEND_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             faz1,
   input  logic             faz2,
   input  logic             faz3,
   input  logic             faz4,
   input  logic             issi,
   input  logic [NCHAN-1:0] inc_req,
   input  logic [NCHAN-1:0] dec_req,
   input  logic [NCHAN-1:0] ovf_clr,
   output logic             cmd_plus,
   output logic             cmd_minus,
   output logic [2:0]       cmd_chan,
   output logic             busy,
   output logic [NCHAN-1:0] ovf,
   output logic             seq_err
);

   localparam int CW = chan_w(NCHAN);

   state_t                   state;
   logic [CW-1:0]            rr, winner, pick;
   logic                     dir, pick_dir, any_nz;
   logic                     multi, retire_now;
   logic [2:0]               nstb;
   logic [NCHAN-1:0]         retire_vec;
   logic signed [PEND_W-1:0] pend [NCHAN];
   int                       idx;

   assign nstb       = 3'(faz1) + 3'(faz2) + 3'(faz3) + 3'(faz4);
   assign multi      = nstb > 3'd1;
   // Both a clean faz4 and an early faz1 in HOLD retire the already-issued command
   assign retire_now = (state == HOLD) && !multi && (faz4 || faz1);

   for (genvar g = 0; g < NCHAN; g++) begin : g_acc
      assign retire_vec[g] = retire_now && (winner == CW'(g));
      cdu_pend_acc #(.PEND_W(PEND_W)) u_acc (
         .clk        (clk),
         .rst        (rst),
         .inc        (inc_req[g]),
         .dec        (dec_req[g]),
         .retire     (retire_vec[g]),
         .retire_dir (dir),
         .ovf_clr    (ovf_clr[g]),
         .pend       (pend[g]),
         .ovf        (ovf[g])
      );
   end

   always_comb begin
      pick   = '0;
      any_nz = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NCHAN; k++) begin
         idx = (int'(rr) + k) % NCHAN;
         if (!any_nz && pend[idx] != '0) begin
            any_nz = 1'b1;
            pick   = CW'(idx);
         end
      end
      pick_dir = pend[pick][PEND_W-1] ? DIR_MINUS : DIR_PLUS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr        <= CW'(NCHAN - 1);
         winner    <= '0;
         dir       <= DIR_PLUS;
         cmd_plus  <= 1'b0;
         cmd_minus <= 1'b0;
         cmd_chan  <= 3'd0;
         busy      <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         cmd_plus  <= 1'b0;
         cmd_minus <= 1'b0;
         cmd_chan  <= 3'd0;
         if (multi) begin
            seq_err <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (faz1 && !issi && any_nz) begin
                     state  <= SEL;
                     winner <= pick;
                     dir    <= pick_dir;
                     busy   <= 1'b1;
                  end
               end
               SEL: begin
                  if (faz2) begin
                     state     <= HOLD;
                     cmd_plus  <= (dir == DIR_PLUS);
                     cmd_minus <= (dir == DIR_MINUS);
                     cmd_chan  <= 3'(winner);
                  end else if (faz3 || faz4) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     seq_err <= 1'b1;
                  end
               end
               HOLD: begin
                  if (faz4 || faz1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     rr    <= winner;
                     if (faz1)
                        seq_err <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cdu_counter_scheduler.sv
// tb/tb_cdu_counter_scheduler.sv - directed scoreboard bench for cdu_counter_scheduler
module tb_cdu_counter_scheduler;

   localparam int NCHAN  = 5;
   localparam int PEND_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             faz1 = 1'b0, faz2 = 1'b0, faz3 = 1'b0, faz4 = 1'b0;
   logic             issi = 1'b0;
   logic [NCHAN-1:0] inc_req = '0, dec_req = '0, ovf_clr = '0;
   logic             cmd_plus, cmd_minus, busy, seq_err;
   logic [2:0]       cmd_chan;
   logic [NCHAN-1:0] ovf;

   int               vectors = 0;
   int               miscompares = 0;
   logic [4:0]       sb [$];
   logic [4:0]       exp_cmd;

   cdu_counter_scheduler #(.NCHAN(NCHAN), .PEND_W(PEND_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .faz1      (faz1),
      .faz2      (faz2),
      .faz3      (faz3),
      .faz4      (faz4),
      .issi      (issi),
      .inc_req   (inc_req),
      .dec_req   (dec_req),
      .ovf_clr   (ovf_clr),
      .cmd_plus  (cmd_plus),
      .cmd_minus (cmd_minus),
      .cmd_chan  (cmd_chan),
      .busy      (busy),
      .ovf       (ovf),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop: every issued command must match the oldest expected one
   always @(negedge clk) begin
      if (cmd_plus || cmd_minus) begin
         if (sb.size() == 0) begin
            vectors++;
            assert (sb.size() != 0) else begin
               miscompares++;
               $error("FAIL cmd_unexpected observed=%b expected=none", {cmd_plus, cmd_minus, cmd_chan});
            end
         end else begin
            exp_cmd = sb.pop_front();
            chk("cmd", {27'd0, cmd_plus, cmd_minus, cmd_chan}, {27'd0, exp_cmd});
         end
      end
   end

   function automatic logic [4:0] plus_cmd(input int ch);
      return {1'b1, 1'b0, 3'(ch)};
   endfunction

   function automatic logic [4:0] minus_cmd(input int ch);
      return {1'b0, 1'b1, 3'(ch)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int n);
      faz1 = (n == 1);
      faz2 = (n == 2);
      faz3 = (n == 3);
      faz4 = (n == 4);
      cyc();
      {faz1, faz2, faz3, faz4} = 4'b0;
   endtask

   task automatic frame();
      strobe(1); cyc();
      strobe(2); cyc();
      strobe(3); cyc();
      strobe(4); cyc();
   endtask

   task automatic pulse_inc(input int ch);
      inc_req[ch] = 1'b1;
      cyc();
      inc_req = '0;
   endtask

   task automatic pulse_dec(input int ch);
      dec_req[ch] = 1'b1;
      cyc();
      dec_req = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      chk("rst cmd_plus", {31'd0, cmd_plus}, 0);
      chk("rst cmd_minus", {31'd0, cmd_minus}, 0);
      chk("rst cmd_chan", {29'd0, cmd_chan}, 0);
      chk("rst busy", {31'd0, busy}, 0);
      chk("rst ovf", {27'd0, ovf}, 0);
      chk("rst seq_err", {31'd0, seq_err}, 0);

      // 1: single ch2 request
      pulse_inc(2);
      chk("t1 pend2 pre", dut.pend[2], 1);
      sb.push_back(plus_cmd(2));
      strobe(1);
      chk("t1 busy sel", {31'd0, busy}, 1);
      cyc(); strobe(2); cyc(); strobe(3); cyc(); strobe(4); cyc();
      chk("t1 pend2", dut.pend[2], 0);
      chk("t1 busy end", {31'd0, busy}, 0);
      chk("t1 sb", sb.size(), 0);

      // 2: round-robin over ch0, ch1, ch4
      do_reset();
      inc_req = 5'b10011;
      cyc();
      inc_req = '0;
      sb.push_back(plus_cmd(0));
      sb.push_back(plus_cmd(1));
      sb.push_back(plus_cmd(4));
      repeat (3) frame();
      chk("t2 busy", {31'd0, busy}, 0);
      chk("t2 sb", sb.size(), 0);
      chk("t2 pend4", dut.pend[4], 0);

      // 3: saturation, overflow flag and clear
      do_reset();
      repeat (8) pulse_inc(3);
      chk("t3 pend3 sat", dut.pend[3], 7);
      chk("t3 ovf set", {27'd0, ovf}, 32'h08);
      ovf_clr[3] = 1'b1;
      cyc();
      ovf_clr = '0;
      chk("t3 ovf clr", {27'd0, ovf}, 0);
      repeat (7) sb.push_back(plus_cmd(3));
      repeat (7) frame();
      chk("t3 pend3 drained", dut.pend[3], 0);
      chk("t3 sb", sb.size(), 0);
      frame();
      repeat (7) pulse_inc(3);
      chk("t3 ovf no drop", {27'd0, ovf}, 0);
      inc_req[3] = 1'b1;
      ovf_clr[3] = 1'b1;
      cyc();
      inc_req = '0;
      ovf_clr = '0;
      chk("t3 set beats clr", {27'd0, ovf}, 32'h08);

      // 4: issi blocks the grant
      do_reset();
      pulse_dec(1);
      pulse_dec(1);
      chk("t4 pend1 pre", dut.pend[1], -2);
      issi = 1'b1;
      strobe(1);
      chk("t4 busy blocked", {31'd0, busy}, 0);
      cyc(); strobe(2); cyc(); strobe(3); cyc(); strobe(4); cyc();
      issi = 1'b0;
      chk("t4 pend1 held", dut.pend[1], -2);
      sb.push_back(minus_cmd(1));
      sb.push_back(minus_cmd(1));
      repeat (2) frame();
      chk("t4 pend1", dut.pend[1], 0);
      chk("t4 sb", sb.size(), 0);

      // 5: out-of-order strobe in SEL, then reset mid-HOLD
      do_reset();
      pulse_inc(0);
      strobe(1);
      chk("t5 busy sel", {31'd0, busy}, 1);
      cyc();
      strobe(4);
      chk("t5 seq_err", {31'd0, seq_err}, 1);
      chk("t5 busy idle", {31'd0, busy}, 0);
      chk("t5 pend0 kept", dut.pend[0], 1);
      sb.push_back(plus_cmd(0));
      strobe(1); cyc();
      strobe(2); cyc();
      chk("t5 sb", sb.size(), 0);
      chk("t5 busy hold", {31'd0, busy}, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5 rst busy", {31'd0, busy}, 0);
      chk("t5 rst seq_err", {31'd0, seq_err}, 0);
      chk("t5 rst cmd", {27'd0, cmd_plus, cmd_minus, cmd_chan}, 0);
      chk("t5 rst ovf", {27'd0, ovf}, 0);
      chk("t5 rst pend0", dut.pend[0], 0);
      cyc();
      rst = 1'b0;
      cyc();

      // 6: opposing requests drive pend through zero while a +1 is in flight
      pulse_inc(0);
      sb.push_back(plus_cmd(0));
      strobe(1); cyc();
      strobe(2); cyc();
      pulse_dec(0);
      pulse_dec(0);
      strobe(3); cyc();
      strobe(4); cyc();
      chk("t6 pend0", dut.pend[0], -2);
      sb.push_back(minus_cmd(0));
      sb.push_back(minus_cmd(0));
      repeat (2) frame();
      chk("t6 pend0 drained", dut.pend[0], 0);

      // simultaneous strobes
      {faz1, faz2} = 2'b11;
      cyc();
      {faz1, faz2} = 2'b00;
      chk("multi seq_err", {31'd0, seq_err}, 1);
      chk("multi busy", {31'd0, busy}, 0);

      cyc(); cyc();
      chk("final sb", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
